jtag_tap_ctrl: RTL

//   IEEE 1149.1-style TAP controller that sequences the JTAG test datapath in front of the SoC under test.

---
 rtl/jtag_pkg.sv | 48 ++++
 rtl/jtag_tap_fsm.sv | 47 ++++
 rtl/jtag_tap_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE state encoding, opcodes, capture pattern
// and the next-state function of the 16-state TAP graph.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PA_DR  = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PA_IR  = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS, DR_IDCODE, DR_SAMPLE, DR_TESTSEL
    } dr_sel_t;

    localparam logic [3:0] OP_IDCODE   = 4'h1;
    localparam logic [3:0] OP_SAMPLE   = 4'h2;
    localparam logic [3:0] OP_TESTSEL  = 4'h3;
    localparam logic [3:0] OP_RUNBIST  = 4'h4;
    localparam logic [3:0] OP_SOCRESET = 4'h5;
    localparam logic [3:0] OP_BYPASS   = 4'hF;

    // Low bits loaded into the IR shift register at Capture-IR
    localparam logic [1:0] IR_CAPTURE  = 2'b01;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TLR:     tap_next = tms ? TLR    : RTI;
            RTI:     tap_next = tms ? SEL_DR : RTI;
            SEL_DR:  tap_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = tms ? UPD_DR : PA_DR;
            PA_DR:   tap_next = tms ? EX2_DR : PA_DR;
            EX2_DR:  tap_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = tms ? SEL_DR : RTI;
            SEL_IR:  tap_next = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_next = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = tms ? UPD_IR : PA_IR;
            PA_IR:   tap_next = tms ? EX2_IR : PA_IR;
            EX2_IR:  tap_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = tms ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state machine: tracks the 16-state graph on TCK and publishes
// registered one-hot decodes of the current state for the datapath.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state,
    output logic       enter_tlr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_t state_nxt;

    assign state_nxt = tap_next(state, TMS);

    // Look-ahead: the coming edge lands in (or stays in) Test-Logic-Reset
    assign enter_tlr = (state_nxt == TLR);

    // State register with decodes registered alongside so they track state exactly
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state      <= TLR;
            capture_ir <= 1'b0;
            shift_ir   <= 1'b0;
            update_ir  <= 1'b0;
            capture_dr <= 1'b0;
            shift_dr   <= 1'b0;
            update_dr  <= 1'b0;
        end else begin
            state      <= state_nxt;
            capture_ir <= (state_nxt == CAP_IR);
            shift_ir   <= (state_nxt == SH_IR);
            update_ir  <= (state_nxt == UPD_IR);
            capture_dr <= (state_nxt == CAP_DR);
            shift_dr   <= (state_nxt == SH_DR);
            update_dr  <= (state_nxt == UPD_DR);
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller top: instruction register, data registers, TDO mux
// and the registered SoC test controls driven by the active instruction.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned  IR_WIDTH   = 4,
    parameter int unsigned  DR_WIDTH   = 32,
    parameter logic [31:0]  IDCODE_VAL = 32'h1000_0001
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_OE,
    input  logic [DR_WIDTH-1:0] socOutput,
    output logic                socTestSel,
    output logic                socRST,
    output logic                socClkEn,
    output logic [3:0]          tapState
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);

    tap_state_t          state;
    logic                enter_tlr;
    logic                capture_ir, shift_ir, update_ir;
    logic                capture_dr, shift_dr, update_dr;
    logic [IR_WIDTH-1:0] ir_sr, ir;
    logic [31:0]         id_sr;
    logic [DR_WIDTH-1:0] samp_sr;
    logic                ts_sr, byp_sr, dr_lsb;
    dr_sel_t             dr_sel;

    jtag_tap_fsm u_fsm (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .enter_tlr  (enter_tlr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    assign tapState = state;
    assign TDO_OE   = shift_ir | shift_dr;

    // Instruction decode to DR selection; unknown opcodes fall back to bypass
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir == IR_WIDTH'(OP_IDCODE))       dr_sel = DR_IDCODE;
        else if (ir == IR_WIDTH'(OP_SAMPLE))  dr_sel = DR_SAMPLE;
        else if (ir == IR_WIDTH'(OP_TESTSEL)) dr_sel = DR_TESTSEL;
    end

    // IR shift/update; socRST is registered with the IR so it mirrors SOCRESET exactly
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr  <= '0;
            ir     <= IR_IDCODE;
            socRST <= 1'b0;
        end else begin
            if (capture_ir)    ir_sr <= IR_WIDTH'(IR_CAPTURE);
            else if (shift_ir) ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
            if (enter_tlr) begin
                ir     <= IR_IDCODE;
                socRST <= 1'b0;
            end else if (update_ir) begin
                ir     <= ir_sr;
                socRST <= (ir_sr == IR_WIDTH'(OP_SOCRESET));
            end
        end
    end

    // Capture and shift of the selected data register; pause/exit hold contents
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            id_sr   <= '0;
            samp_sr <= '0;
            ts_sr   <= 1'b0;
            byp_sr  <= 1'b0;
        end else if (capture_dr) begin
            case (dr_sel)
                DR_IDCODE:  id_sr   <= IDCODE_VAL;
                DR_SAMPLE:  samp_sr <= socOutput;
                DR_TESTSEL: ts_sr   <= socTestSel;
                default:    byp_sr  <= 1'b0;
            endcase
        end else if (shift_dr) begin
            case (dr_sel)
                DR_IDCODE:  id_sr   <= {TDI, id_sr[31:1]};
                DR_SAMPLE:  samp_sr <= {TDI, samp_sr[DR_WIDTH-1:1]};
                DR_TESTSEL: ts_sr   <= TDI;
                default:    byp_sr  <= TDI;
            endcase
        end
    end

    // Test-select latch written from the 1-bit TESTSEL register at Update-DR
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST)                                 socTestSel <= 1'b0;
        else if (update_dr && dr_sel == DR_TESTSEL) socTestSel <= ts_sr;
    end

    // SoC clock enable follows RTI under RUNBIST, one TCK behind
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST)          socClkEn <= 1'b0;
        else if (enter_tlr) socClkEn <= 1'b0;
        else                socClkEn <= (state == RTI) && (ir == IR_WIDTH'(OP_RUNBIST));
    end

    // Serial output: LSB of whichever shift path is active, quiet otherwise
    always_comb begin
        case (dr_sel)
            DR_IDCODE:  dr_lsb = id_sr[0];
            DR_SAMPLE:  dr_lsb = samp_sr[0];
            DR_TESTSEL: dr_lsb = ts_sr;
            default:    dr_lsb = byp_sr;
        endcase
        TDO = 1'b0;
        if (shift_ir)      TDO = ir_sr[0];
        else if (shift_dr) TDO = dr_lsb;
    end

endmodule
